// File: rtl/mips_generic_definitions_pkg.sv
// Shared MIPS core definitions: instruction ROM geometry plus the fetch-sequencer
// state encoding and program-counter constants.
package MIPS_Generic_Definitions;

    localparam int Instruction_Width          = 32;
    localparam int Instruction_Mem_Addr_Width = 5;
    localparam int Instruction_Mem_Depth      = 32;

    localparam int                    PC_Width       = 32;
    localparam logic [PC_Width-1:0]   Fetch_Reset_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_FAULT
    } fetch_state_e;

endpackage

// File: rtl/mips_ifid_stage.sv
// IF/ID pipeline register: holds one fetched instruction and its PC, with a
// load strobe from the fetch sequencer and a flush that drops the valid bit.
module mips_ifid_stage
    import MIPS_Generic_Definitions::*;
#(
    parameter int INSTR_W  = Instruction_Width,
    parameter int PC_WIDTH = PC_Width
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                load,
    input  logic [INSTR_W-1:0]  load_instr,
    input  logic [PC_WIDTH-1:0] load_pc,
    output logic                valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [PC_WIDTH-1:0] pc
);

    logic                valid_d, valid_q;
    logic [INSTR_W-1:0]  instr_d, instr_q;
    logic [PC_WIDTH-1:0] pc_d,    pc_q;

    // Flush only clears valid; the stale payload is harmless once invalid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/mips_fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational ROM,
// feeds the IF/ID register, applies redirects and traps out-of-range fetches.
module mips_fetch_controller
    import MIPS_Generic_Definitions::*;
#(
    parameter int                  PC_WIDTH = PC_Width,
    parameter logic [PC_WIDTH-1:0] RESET_PC = Fetch_Reset_PC,
    parameter int                  ADDR_W   = Instruction_Mem_Addr_Width,
    parameter int                  INSTR_W  = Instruction_Width,
    parameter int                  DEPTH    = Instruction_Mem_Depth
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                fault,
    output logic [PC_WIDTH-1:0] fault_pc,
    output logic [31:0]         fetch_count
);

    fetch_state_e        state_d, state_q;
    logic [PC_WIDTH-1:0] pc_d, pc_q;
    logic                fault_d, fault_q;
    logic [PC_WIDTH-1:0] fault_pc_d, fault_pc_q;
    logic [31:0]         fetch_count_d, fetch_count_q;

    logic stage_flush;
    logic stage_load;
    logic advance;
    logic accept;
    logic pc_out_of_range;

    assign rom_addr = pc_q[ADDR_W+1:2];

    // Either the word index is past the ROM or high PC bits address beyond it.
    assign pc_out_of_range =
        (pc_q[PC_WIDTH-1:ADDR_W+2] != '0) ||
        ({{(PC_WIDTH-ADDR_W){1'b0}}, pc_q[ADDR_W+1:2]} >= PC_WIDTH'(DEPTH));

    assign advance = !if_valid || if_ready;
    assign accept  = if_valid && if_ready && !redirect_valid && !halt;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = accept ? fetch_count_q + 32'd1 : fetch_count_q;
        stage_flush   = 1'b0;
        stage_load    = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                stage_flush = 1'b1;
                if (!halt && start) begin
                    state_d = FETCH_RUN;
                    pc_d    = RESET_PC;
                end
            end

            FETCH_RUN: begin
                if (halt) begin
                    state_d     = FETCH_IDLE;
                    stage_flush = 1'b1;
                end else if (redirect_valid) begin
                    // The wrong-path instruction is dropped even if decode takes it now.
                    stage_flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d    = FETCH_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (pc_out_of_range) begin
                    state_d     = FETCH_FAULT;
                    fault_d     = 1'b1;
                    fault_pc_d  = pc_q;
                    stage_flush = 1'b1;
                end else if (advance) begin
                    stage_load = 1'b1;
                    pc_d       = pc_q + PC_WIDTH'(4);
                end
            end

            FETCH_FAULT: begin
                stage_flush = 1'b1;
                if (halt) begin
                    state_d = FETCH_IDLE;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d     = FETCH_IDLE;
                stage_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    mips_ifid_stage #(
        .INSTR_W  (INSTR_W),
        .PC_WIDTH (PC_WIDTH)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (stage_flush),
        .load       (stage_load),
        .load_instr (rom_data),
        .load_pc    (pc_q),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_mips_fetch_controller.sv
// Directed bench for mips_fetch_controller: a 32-word ROM instance and a
// 16-word instance share stimulus; expected values are hand-computed.
module tb_mips_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;

    logic [4:0]  rom_addr, rom_addr16;
    logic [31:0] rom_data, rom_data16;
    logic        if_valid, if_valid16;
    logic [31:0] if_instr, if_instr16;
    logic [31:0] if_pc, if_pc16;
    logic        fault, fault16;
    logic [31:0] fault_pc, fault_pc16;
    logic [31:0] fetch_count, fetch_count16;

    logic [31:0] rom [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data   = rom[rom_addr];
    assign rom_data16 = rom[rom_addr16];

    mips_fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    mips_fetch_controller #(.DEPTH(16)) dut16 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .rom_addr       (rom_addr16),
        .rom_data       (rom_data16),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid16),
        .if_ready       (if_ready),
        .if_instr       (if_instr16),
        .if_pc          (if_pc16),
        .fault          (fault16),
        .fault_pc       (fault_pc16),
        .fetch_count    (fetch_count16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h2008_0001 + 32'(i);

        rst_n = 1'b0; start = 1'b0; halt = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        #23;
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_no_fetch", {31'd0, if_valid}, 32'd0);

        // Sequential fetch at full throughput.
        if_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_valid0", {31'd0, if_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("seq_valid", {31'd0, if_valid}, 32'd1);
            check("seq_pc", if_pc, 32'(4 * k));
            check("seq_instr", if_instr, 32'h2008_0001 + 32'(k));
            check("seq_count", fetch_count, 32'(k));
        end

        // Decode stall holding if_pc=8.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_valid", {31'd0, if_valid}, 32'd0);
        check("halt_count", fetch_count, 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("pre_stall_pc", if_pc, 32'h8);
        check("pre_stall_count", fetch_count, 32'd6);
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc", if_pc, 32'h8);
            check("stall_instr", if_instr, 32'h2008_0003);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_rom_addr", {27'd0, rom_addr}, 32'd3);
            check("stall_count", fetch_count, 32'd6);
        end
        if_ready = 1'b1;
        tick();
        check("release_pc", if_pc, 32'hC);
        check("release_count", fetch_count, 32'd7);

        // Redirect flushes the instruction at 0x10 without counting it.
        tick();
        check("pre_redir_pc", if_pc, 32'h10);
        check("pre_redir_count", fetch_count, 32'd8);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", {31'd0, if_valid}, 32'd0);
        check("redir_count", fetch_count, 32'd8);
        tick();
        check("redir_pc", if_pc, 32'h40);
        check("redir_instr", if_instr, 32'h2008_0011);
        check("redir_valid", {31'd0, if_valid}, 32'd1);
        tick();
        check("post_redir_pc", if_pc, 32'h44);
        check("post_redir_count", fetch_count, 32'd9);

        // Misaligned redirect traps; halt clears; start restarts at RESET_PC.
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_fault_pc", fault_pc, 32'h42);
        check("mis_valid", {31'd0, if_valid}, 32'd0);
        check("mis_count", fetch_count, 32'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fault_sticky", {31'd0, fault}, 32'd1);
        check("fault_start_ignored", {31'd0, if_valid}, 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_clears_fault", {31'd0, fault}, 32'd0);
        halt = 1'b1; start = 1'b1;
        tick();
        halt = 1'b0; start = 1'b0;
        tick();
        check("halt_beats_start", {31'd0, if_valid}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart_pc", if_pc, 32'h0);
        check("restart_valid", {31'd0, if_valid}, 32'd1);

        // Redirect above the ROM's address space traps on the high-bit check.
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check("hi_no_fault_yet", {31'd0, fault}, 32'd0);
        tick();
        check("hi_fault", {31'd0, fault}, 32'd1);
        check("hi_fault_pc", fault_pc, 32'h80);
        check("hi_valid", {31'd0, if_valid}, 32'd0);

        // DEPTH=16 instance runs off the end of its ROM.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check("d16_pc", if_pc16, 32'(4 * k));
            check("d16_valid", {31'd0, if_valid16}, 32'd1);
        end
        tick();
        check("d16_fault", {31'd0, fault16}, 32'd1);
        check("d16_fault_pc", fault_pc16, 32'h40);
        check("d16_valid_off", {31'd0, if_valid16}, 32'd0);
        check("d16_count", fetch_count16, 32'd16);
        check("d32_no_fault", {31'd0, fault}, 32'd0);
        check("d32_pc", if_pc, 32'h40);
        tick();
        check("d16_stays_off", {31'd0, if_valid16}, 32'd0);

        // Asynchronous reset mid-stream at pc=0x20.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("pre_arst_pc", if_pc, 32'h1C);
        check("pre_arst_rom_addr", {27'd0, rom_addr}, 32'd8);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, if_valid}, 32'd0);
        check("arst_count", fetch_count, 32'd0);
        check("arst_rom_addr", {27'd0, rom_addr}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick(); tick();
        check("arst_idle", {31'd0, if_valid}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("arst_resume_pc", if_pc, 32'h0);
        check("arst_resume_valid", {31'd0, if_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
